// File: rtl/axis_rr_arbiter_if.sv
// Handshake bundle between one crossbar output port and its arbiter.
// The crossbar side drives per-source valid/last and the downstream ready;
// the arbiter side returns the one-hot grant, its index and the timeout pulse.
interface axis_rr_arbiter_if #(
    parameter int NUM_REQUEST = 4
);
    localparam int IDX_W = $clog2(NUM_REQUEST);

    logic [NUM_REQUEST-1:0] request_i;
    logic [NUM_REQUEST-1:0] s_last_i;
    logic                   m_ready_i;
    logic [NUM_REQUEST-1:0] grant_o;
    logic [IDX_W-1:0]       grant_idx_o;
    logic                   grant_valid_o;
    logic                   timeout_o;

    // Crossbar / source side of the port.
    modport master (
        output request_i,
        output s_last_i,
        output m_ready_i,
        input  grant_o,
        input  grant_idx_o,
        input  grant_valid_o,
        input  timeout_o
    );

    // Arbiter side of the port.
    modport slave (
        input  request_i,
        input  s_last_i,
        input  m_ready_i,
        output grant_o,
        output grant_idx_o,
        output grant_valid_o,
        output timeout_o
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter for one stream crossbar output port.
// A grant is held for a whole packet (until the granted source hands over a
// beat carrying tlast); priority then rotates to the source after the one
// just served. An optional beat limit force-releases runaway packets.
// Re-arbitration happens in the release cycle, so packets go back-to-back.
module axis_rr_arbiter #(
    parameter int NUM_REQUEST = 4,
    parameter int MAX_BEATS   = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    axis_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQUEST);
    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    // Highest source index, used for the modulo-N wrap of the pointer.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUEST - 1);
    // Counter value seen on the handshake that completes the limit beat.
    localparam logic [CNT_W-1:0] LIMIT_M1 = (MAX_BEATS > 0) ? CNT_W'(MAX_BEATS - 1) : '0;
    localparam bit               LIMIT_EN = (MAX_BEATS > 0);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // Advance an index by one, wrapping at NUM_REQUEST (works for any N).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // One-hot encode a source index.
    function automatic logic [NUM_REQUEST-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQUEST-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotating first-set search starting at ptr. Scanning from the farthest
    // offset down to offset 0 lets the nearest requester overwrite the rest.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] rr_search(
        input logic [NUM_REQUEST-1:0] req,
        input logic [IDX_W-1:0]       ptr
    );
        logic [IDX_W:0] res;
        int             k;
        res = '0;
        for (int i = NUM_REQUEST - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_REQUEST;
            if (req[k]) begin
                res = {1'b1, IDX_W'(k)};
            end
        end
        return res;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_REQUEST-1:0] r_grant;
    logic [NUM_REQUEST-1:0] w_grant_nxt;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       w_grant_idx_nxt;
    logic [IDX_W-1:0]       r_prio_ptr;
    logic [IDX_W-1:0]       w_prio_ptr_nxt;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [CNT_W-1:0]       w_beat_cnt_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;

    logic                   w_hs;
    logic                   w_last;
    logic                   w_rel_last;
    logic                   w_rel_timeout;
    logic                   w_release;
    logic [IDX_W-1:0]       w_arb_ptr;
    logic                   w_win_vld;
    logic [IDX_W-1:0]       w_win_idx;

    // Qualify the granted source's handshake and the two release causes;
    // non-granted sources' valid/last never reach this logic.
    always_comb begin
        w_hs          = bus.request_i[r_grant_idx] & bus.m_ready_i;
        w_last        = bus.s_last_i[r_grant_idx];
        w_rel_last    = (r_state == S_LOCKED) & w_hs & w_last;
        w_rel_timeout = (r_state == S_LOCKED) & w_hs & LIMIT_EN
                      & (r_beat_cnt == LIMIT_M1) & ~w_last;
        w_release     = w_rel_last | w_rel_timeout;
    end

    // Arbitrate from the pointer as it will be after this cycle, so a
    // release hands over to the next winner without a bubble.
    always_comb begin
        w_arb_ptr              = w_release ? wrap_inc(r_grant_idx) : r_prio_ptr;
        {w_win_vld, w_win_idx} = rr_search(bus.request_i, w_arb_ptr);
    end

    // Next-state and register-input logic for the IDLE/LOCKED machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_prio_ptr_nxt  = r_prio_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt     = S_LOCKED;
                    w_grant_nxt     = to_onehot(w_win_idx);
                    w_grant_idx_nxt = w_win_idx;
                    w_beat_cnt_nxt  = '0;
                end else begin
                    w_grant_nxt     = '0;
                end
            end
            S_LOCKED: begin
                if (w_release) begin
                    w_prio_ptr_nxt = w_arb_ptr;
                    w_timeout_nxt  = w_rel_timeout;
                    w_beat_cnt_nxt = '0;
                    if (w_win_vld) begin
                        // May re-grant the same source if it is the only requester.
                        w_grant_nxt     = to_onehot(w_win_idx);
                        w_grant_idx_nxt = w_win_idx;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_grant_nxt     = '0;
                    end
                end else if (w_hs) begin
                    // tvalid gaps and stalls leave both grant and count untouched.
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State register; reset drops any grant and restarts priority at source 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_prio_ptr  <= '0;
            r_beat_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_prio_ptr  <= w_prio_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.grant_o       = r_grant;
    assign bus.grant_idx_o   = r_grant_idx;
    assign bus.grant_valid_o = |r_grant;
    assign bus.timeout_o     = r_timeout;
endmodule
